// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - 4-bit gray-scale frame store with coordinate write port and line-repeating raster read.
module frame_buffer #(
    parameter int FB_WIDTH     = 100,
    parameter int FB_HEIGHT    = 75,
    parameter int WIDTH_REPEAT = 4,
    localparam int ADDR_W      = $clog2(FB_WIDTH * FB_HEIGHT),
    localparam int X_W         = $clog2(FB_WIDTH),
    localparam int Y_W         = $clog2(FB_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_REPEAT-1:0] i_line_repeat,
    input  logic                    i_next_pixel_in,
    input  logic                    i_frame_reset_in,
    output logic [3:0]              o_pixel_out,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [X_W-1:0]          i_wr_x,
    input  logic [Y_W-1:0]          i_wr_y,
    input  logic [3:0]              i_wr_pixel,
    output logic                    o_wr_error,
    input  logic                    i_clear_in,
    input  logic [3:0]              i_clear_value
);

    localparam int                FB_SIZE   = FB_WIDTH * FB_HEIGHT;
    localparam logic [X_W-1:0]    COL_LAST  = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0]    ROW_LAST  = Y_W'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_WIDTH);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } wr_state_t;

    logic [3:0] r_mem [FB_SIZE];

    // Read side
    logic [ADDR_W-1:0]       r_rd_addr, w_rd_addr_next;
    logic [ADDR_W-1:0]       r_line_base, w_line_base_next;
    logic [X_W-1:0]          r_col_ctr, w_col_ctr_next;
    logic [WIDTH_REPEAT-1:0] r_rep_ctr, w_rep_ctr_next;
    logic [Y_W-1:0]          r_row_ctr, w_row_ctr_next;
    logic                    r_next_prev;
    logic                    w_edge;
    logic                    w_load;

    always_comb begin
        w_edge           = i_next_pixel_in && !r_next_prev;
        w_load           = 1'b0;
        w_rd_addr_next   = r_rd_addr;
        w_line_base_next = r_line_base;
        w_col_ctr_next   = r_col_ctr;
        w_rep_ctr_next   = r_rep_ctr;
        w_row_ctr_next   = r_row_ctr;
        if (i_frame_reset_in) begin
            w_load           = 1'b1;
            w_rd_addr_next   = '0;
            w_line_base_next = '0;
            w_col_ctr_next   = '0;
            w_rep_ctr_next   = '0;
            w_row_ctr_next   = '0;
        end else if (w_edge) begin
            w_load = 1'b1;
            if (r_col_ctr < COL_LAST) begin
                w_col_ctr_next = r_col_ctr + 1'b1;
                w_rd_addr_next = r_rd_addr + 1'b1;
            end else begin
                w_col_ctr_next = '0;
                if (r_rep_ctr < i_line_repeat) begin
                    w_rep_ctr_next = r_rep_ctr + 1'b1;
                    w_rd_addr_next = r_line_base;
                end else if (r_row_ctr == ROW_LAST) begin
                    w_rep_ctr_next   = '0;
                    w_row_ctr_next   = '0;
                    w_line_base_next = '0;
                    w_rd_addr_next   = '0;
                end else begin
                    w_rep_ctr_next   = '0;
                    w_row_ctr_next   = r_row_ctr + 1'b1;
                    w_line_base_next = r_line_base + LINE_STEP;
                    w_rd_addr_next   = r_line_base + LINE_STEP;
                end
            end
        end
    end

    // next_prev resets high so a request already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_line_base <= '0;
            r_col_ctr   <= '0;
            r_rep_ctr   <= '0;
            r_row_ctr   <= '0;
            r_next_prev <= 1'b1;
            o_pixel_out <= 4'd0;
        end else begin
            r_rd_addr   <= w_rd_addr_next;
            r_line_base <= w_line_base_next;
            r_col_ctr   <= w_col_ctr_next;
            r_rep_ctr   <= w_rep_ctr_next;
            r_row_ctr   <= w_row_ctr_next;
            r_next_prev <= i_next_pixel_in;
            if (w_load) begin
                o_pixel_out <= r_mem[w_rd_addr_next];
            end
        end
    end

    // Write side
    wr_state_t         r_state, w_state_next;
    logic              r_live;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [3:0]        r_clr_value;
    logic              w_clr_start;
    logic              w_err_next;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [3:0]        w_wdata;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_in_range = (32'(i_wr_x) < FB_WIDTH) && (32'(i_wr_y) < FB_HEIGHT);
    assign w_wr_addr  = ADDR_W'(i_wr_y) * LINE_STEP + ADDR_W'(i_wr_x);

    always_comb begin
        w_state_next = r_state;
        o_wr_ready   = 1'b0;
        w_clr_start  = 1'b0;
        w_err_next   = 1'b0;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (r_live) begin
                    if (i_clear_in) begin
                        w_clr_start  = 1'b1;
                        w_state_next = S_CLEAR;
                    end else begin
                        o_wr_ready = 1'b1;
                        if (i_wr_valid) begin
                            if (w_in_range) begin
                                w_we    = 1'b1;
                                w_waddr = w_wr_addr;
                                w_wdata = i_wr_pixel;
                            end else begin
                                w_err_next = 1'b1;
                            end
                        end
                    end
                end
            end
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = r_clr_value;
                if (r_clr_addr == ADDR_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_clr_addr  <= '0;
            r_clr_value <= 4'd0;
            o_wr_error  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_live     <= 1'b1;
            o_wr_error <= w_err_next;
            if (w_clr_start) begin
                r_clr_addr  <= '0;
                r_clr_value <= i_clear_value;
            end else if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    // Contents are never reset; a reset mid-clear leaves the frame partially filled
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule
